// File: rtl/msg_arbiter_rr.sv
// rtl/msg_arbiter_rr.sv - round-robin message arbiter and frame serialiser
//
// Collects messages from N_SRC show-ahead message sources and serialises one
// frame at a time onto a registered valid/ready byte stream:
//   SYNC_BYTE, source index, length L, L payload bytes [, XOR checksum]
//
// Optional feature macro: MSG_ARBITER_CHECKSUM_EN
//   defined   -> checksum byte (XOR of address, length and payload) appended
//   undefined -> no checksum state or accumulator
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   have_msg_bus  per-source "complete message queued" flags
//   len_bus       per-source payload length, bits [8*i+:8]
//   data_bus      per-source current payload byte, bits [8*i+:8]
//   rdreq_bus     per-source one-cycle pop strobe
//   tx_data       frame byte (registered)
//   tx_valid      tx_data valid (registered)
//   tx_ready      downstream accepts the byte
//   busy          frame in progress
module msg_arbiter_rr #(
    parameter int          N_SRC     = 24,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     have_msg_bus,
    input  logic [8*N_SRC-1:0]   len_bus,
    input  logic [8*N_SRC-1:0]   data_bus,
    output logic [N_SRC-1:0]     rdreq_bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ADDR,
        S_LEN,
        S_LOAD,
        S_SEND
`ifdef MSG_ARBITER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    // State entered once the last header/payload byte has gone out.
`ifdef MSG_ARBITER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_IDLE;
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
`ifdef MSG_ARBITER_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic            xfer;
    logic            req_found;
    logic [IW-1:0]   req_idx;
    logic [IW-1:0]   ptr_next;
    logic [7:0]      gnt8;

    assign xfer = tx_valid_q && tx_ready;

    // Round-robin search: first requesting index at or above the pointer,
    // wrapping past N_SRC-1. Candidate arithmetic is 10 bits wide so that
    // ptr + k never overflows for N_SRC up to 256.
    always_comb begin
        logic [9:0] cand;
        logic [9:0] inc;
        cand      = '0;
        inc       = '0;
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = 10'(ptr_q) + 10'(k);
            if (cand >= 10'(N_SRC)) begin
                cand = cand - 10'(N_SRC);
            end
            if (!req_found && have_msg_bus[cand[IW-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[IW-1:0];
            end
        end
        inc      = 10'(req_idx) + 10'd1;
        ptr_next = (inc >= 10'(N_SRC)) ? '0 : inc[IW-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef MSG_ARBITER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef MSG_ARBITER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef MSG_ARBITER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        gnt8            = '0;
        gnt8[IW-1:0]    = gnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    gnt_d      = req_idx;
                    len_d      = len_bus[8*int'(req_idx) +: 8];
                    ptr_d      = ptr_next;
                    cnt_d      = '0;
`ifdef MSG_ARBITER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = S_SYNC;
                end
            end
            S_SYNC: begin
                if (xfer) begin
                    tx_data_d = gnt8;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (xfer) begin
`ifdef MSG_ARBITER_CHECKSUM_EN
                    csum_d    = csum_q ^ tx_data_q;
`endif
                    tx_data_d = len_q;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
`ifdef MSG_ARBITER_CHECKSUM_EN
                    csum_d     = csum_q ^ tx_data_q;
`endif
                    tx_valid_d = 1'b0;
                    state_d    = (len_q == 8'd0) ? S_END : S_LOAD;
                end
            end
            S_LOAD: begin
                // The source FIFO advanced on the previous pop edge, so the
                // granted lane already shows the next byte here.
                tx_data_d  = data_bus[8*int'(gnt_q) +: 8];
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
`ifdef MSG_ARBITER_CHECKSUM_EN
                    csum_d     = csum_q ^ tx_data_q;
`endif
                    tx_valid_d = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                    // Compare in 9 bits so L=255 terminates before the
                    // 8-bit counter wraps.
                    if (({1'b0, cnt_q} + 9'd1) == {1'b0, len_q}) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
`ifdef MSG_ARBITER_CHECKSUM_EN
            S_CSUM: begin
                // First cycle loads the checksum; stays until it is taken.
                if (!tx_valid_q) begin
                    tx_data_d  = csum_q;
                    tx_valid_d = 1'b1;
                end else if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        rdreq_bus = '0;
        if (state_q == S_SEND && xfer) begin
            rdreq_bus[gnt_q] = 1'b1;
        end
        busy     = (state_q != S_IDLE);
        tx_data  = tx_data_q;
        tx_valid = tx_valid_q;
    end

endmodule

// File: tb/tb_msg_arbiter_rr.sv
// tb/tb_msg_arbiter_rr.sv - scoreboard bench for msg_arbiter_rr
module tb_msg_arbiter_rr;

    localparam int N = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      have_msg_bus;
    logic [8*N-1:0]    len_bus;
    logic [8*N-1:0]    data_bus;
    logic [N-1:0]      rdreq_bus;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;

    msg_arbiter_rr #(.N_SRC(N), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .have_msg_bus (have_msg_bus),
        .len_bus      (len_bus),
        .data_bus     (data_bus),
        .rdreq_bus    (rdreq_bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         src;
        bit         pay;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_bad = 0;
    logic [7:0]  mem [N][512];
    int          wr_ptr [N];
    int          rd_ptr [N];
    int          rd_cnt [N];

    // Show-ahead source FIFOs
    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_bus[8*i +: 8] = mem[i][rd_ptr[i]];
        end
    end

    initial begin
        for (int i = 0; i < N; i++) rd_ptr[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (rdreq_bus[i]) rd_ptr[i] = rd_ptr[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks hold stability
    initial begin
        logic       hold;
        logic [7:0] hold_d;
        logic [N-1:0] m;
        exp_t       e;
        hold   = 1'b0;
        hold_d = '0;
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(tx_valid), 32'd1);
                    check("hold_data", 32'(tx_data), 32'(hold_d));
                end
                hold   = tx_valid && !tx_ready;
                hold_d = tx_data;
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                    end else begin
                        e = sb.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(e.b));
                        m = '0;
                        if (e.pay) m[e.src] = 1'b1;
                        check("rdreq_xfer", 32'(rdreq_bus), 32'(m));
                    end
                end else begin
                    check("rdreq_idle", 32'(rdreq_bus), 32'd0);
                end
                for (int i = 0; i < N; i++) begin
                    if (rdreq_bus[i]) rd_cnt[i] = rd_cnt[i] + 1;
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] b, input int src, input bit pay);
        exp_t e;
        e.b   = b;
        e.src = src;
        e.pay = pay;
        sb.push_back(e);
    endtask

    // Queue one message in source src and the frame it should produce
    task automatic add_msg(input int src, input int len, input logic [7:0] seed);
        logic [7:0] cs;
        logic [7:0] b;
        len_bus[8*src +: 8] = 8'(len);
        push_exp(8'hA5, src, 1'b0);
        push_exp(8'(src), src, 1'b0);
        push_exp(8'(len), src, 1'b0);
        cs = 8'(src) ^ 8'(len);
        for (int k = 0; k < len; k++) begin
            b = seed + 8'(k);
            mem[src][wr_ptr[src]] = b;
            wr_ptr[src] = wr_ptr[src] + 1;
            push_exp(b, src, 1'b1);
            cs = cs ^ b;
        end
`ifdef MSG_ARBITER_CHECKSUM_EN
        push_exp(cs, src, 1'b0);
`endif
    endtask

    task automatic start(input logic [N-1:0] mask);
        have_msg_bus = mask;
        @(posedge clk);
        #1;
        have_msg_bus = '0;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, sb.size());
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        wait_empty(budget, name);
        @(posedge clk);
        #1;
        check({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        int g;
        logic pb;
        bit done;
        logic [7:0] pat;
        for (int i = 0; i < N; i++) wr_ptr[i] = 0;
        rst          = 1'b1;
        have_msg_bus = '0;
        len_bus      = '0;
        tx_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_rdreq", 32'(rdreq_bus), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single message, source 3, L=2
        base = rd_cnt[3];
        add_msg(3, 2, 8'h11);
        mem[3][1] = 8'h22;
        sb[4].b = 8'h22;
`ifdef MSG_ARBITER_CHECKSUM_EN
        sb[5].b = 8'h03 ^ 8'h02 ^ 8'h11 ^ 8'h22;
`endif
        have_msg_bus = 24'h000008;
        @(posedge clk);
        #1;
        check("latency_valid", 32'(tx_valid), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
        have_msg_bus = '0;
        wait_drain(100, "single");
        check("single_rdreq_cnt", 32'(rd_cnt[3] - base), 32'd2);

        // Round robin across 0, 5, 23 from a freshly reset pointer
        do_reset();
        for (int r = 0; r < 2; r++) begin
            add_msg(0, 1, 8'h40 + 8'(r));
            add_msg(5, 1, 8'h50 + 8'(r));
            add_msg(23, 1, 8'h70 + 8'(r));
        end
        have_msg_bus = '0;
        have_msg_bus[0]  = 1'b1;
        have_msg_bus[5]  = 1'b1;
        have_msg_bus[23] = 1'b1;
        g  = 0;
        c  = 0;
        pb = 1'b0;
        while (g < 6 && c < 400) begin
            @(posedge clk);
            #1;
            c++;
            if (busy && !pb) g++;
            pb = busy;
        end
        have_msg_bus = '0;
        check("rr_grants", 32'(g), 32'd6);
        wait_drain(200, "rr");

        // Backpressure on an L=4 frame from source 7
        base = rd_cnt[7];
        add_msg(7, 4, 8'hA1);
        pat  = 8'b1001_0110;
        done = 1'b0;
        start(24'h000080);
        fork
            begin
                int i;
                i = 0;
                while (!done) begin
                    tx_ready = pat[i % 8];
                    i++;
                    @(posedge clk);
                    #1;
                end
            end
            begin
                wait_empty(400, "bp");
                done = 1'b1;
            end
        join
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_busy_end", 32'(busy), 32'd0);
        check("bp_rdreq_cnt", 32'(rd_cnt[7] - base), 32'd4);

        // Zero length, source 9
        base = rd_cnt[9];
        add_msg(9, 0, 8'h00);
        start(24'h000200);
        wait_empty(100, "zero");
        check("zero_busy_after", 32'(busy), 32'd0);
        check("zero_rdreq_cnt", 32'(rd_cnt[9] - base), 32'd0);

        // Max length with mid-frame length change, source 1
        base = rd_cnt[1];
        add_msg(1, 255, 8'h00);
        start(24'h000002);
        len_bus[8*1 +: 8] = 8'd3;
        wait_drain(2000, "max");
        check("max_rdreq_cnt", 32'(rd_cnt[1] - base), 32'd255);

        // Reset during SEND, then source 0 wins over source 2
        base = rd_cnt[2];
        add_msg(2, 4, 8'hB0);
        start(24'h000004);
        c = 0;
        while (rd_cnt[2] == base && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("rstmid_first_pop", 32'(rd_cnt[2] - base), 32'd1);
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_in_send", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(tx_valid), 32'd0);
        check("rstmid_rdreq", 32'(rdreq_bus), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_msg(0, 1, 8'hC0);
        start(24'h000005);
        wait_drain(100, "after_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
